// File: rtl/ila_trigger_capture_pkg.sv
// Shared types and constants for the ILA trigger/capture block.
package ila_trigger_capture_pkg;

    typedef enum logic [1:0] {
        ILA_IDLE = 2'd0,
        ILA_PRE  = 2'd1,
        ILA_POST = 2'd2,
        ILA_DONE = 2'd3
    } ila_state_e;

    localparam logic TRIG_LEVEL = 1'b0;
    localparam logic TRIG_EDGE  = 1'b1;

endpackage

// File: rtl/ila_trigger_capture_eval.sv
// Per-bit trigger evaluation (level/edge, optional inversion) and AND/OR reduction over masked bits.
module ila_trigger_capture_eval
    import ila_trigger_capture_pkg::*;
#(
    parameter int unsigned TRIG_W = 4
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic [TRIG_W-1:0] trig_i,
    input  logic [TRIG_W-1:0] trig_type_i,
    input  logic [TRIG_W-1:0] trig_neg_i,
    input  logic [TRIG_W-1:0] trig_mask_i,
    input  logic              trig_and_i,
    output logic              hit_c
);

    logic [TRIG_W-1:0] x_c;
    logic [TRIG_W-1:0] x_q;
    logic [TRIG_W-1:0] bit_hit_c;

    always_comb begin
        x_c       = trig_i ^ trig_neg_i;
        bit_hit_c = '0;
        for (int unsigned i = 0; i < TRIG_W; i++) begin
            if (trig_type_i[i] == TRIG_EDGE) begin
                bit_hit_c[i] = x_c[i] & ~x_q[i];
            end else begin
                bit_hit_c[i] = x_c[i];
            end
        end
        // An empty mask never fires, even though AND over no bits would be vacuously true.
        if (trig_mask_i == '0) begin
            hit_c = 1'b0;
        end else if (trig_and_i) begin
            hit_c = &(bit_hit_c | ~trig_mask_i);
        end else begin
            hit_c = |(bit_hit_c & trig_mask_i);
        end
    end

    // Edge history runs in every state so a trigger may fire on the first armed cycle.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            x_q <= '0;
        end else begin
            x_q <= x_c;
        end
    end

endmodule

// File: rtl/ila_trigger_capture.sv
// ILA capture controller: arms on request, streams probe data into a circular RAM,
// stops after the programmed post-trigger sample count.
module ila_trigger_capture
    import ila_trigger_capture_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TRIG_W = 4,
    parameter int unsigned BUF_AW = 10
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [TRIG_W-1:0] trig_i,
    input  logic [TRIG_W-1:0] trig_type_i,
    input  logic [TRIG_W-1:0] trig_neg_i,
    input  logic [TRIG_W-1:0] trig_mask_i,
    input  logic              trig_and_i,
    input  logic [BUF_AW-1:0] post_cnt_i,
    input  logic              arm_i,
    input  logic              clear_i,
    output logic              buf_we_o,
    output logic [BUF_AW-1:0] buf_addr_o,
    output logic [DATA_W-1:0] buf_wdata_o,
    output logic [BUF_AW-1:0] trig_addr_o,
    output logic [BUF_AW:0]   n_samples_o,
    output logic [1:0]        state_o,
    output logic              done_o
);

    localparam int unsigned CNT_W = BUF_AW + 1;
    localparam logic [CNT_W-1:0] DEPTH = {1'b1, {BUF_AW{1'b0}}};

    logic trig_hit_c;

    ila_state_e        state_q,     state_d;
    logic [BUF_AW-1:0] wr_ptr_q,    wr_ptr_d;
    logic [BUF_AW-1:0] post_cnt_q,  post_cnt_d;
    logic [BUF_AW-1:0] post_left_q, post_left_d;
    logic [CNT_W-1:0]  n_samples_d;
    logic [BUF_AW-1:0] trig_addr_d;
    logic [BUF_AW-1:0] buf_addr_d;
    logic [DATA_W-1:0] buf_wdata_d;
    logic              buf_we_d;
    logic              done_d;

    ila_trigger_capture_eval #(
        .TRIG_W (TRIG_W)
    ) u_eval (
        .clk_i       (clk_i),
        .arst_n_i    (arst_n_i),
        .trig_i      (trig_i),
        .trig_type_i (trig_type_i),
        .trig_neg_i  (trig_neg_i),
        .trig_mask_i (trig_mask_i),
        .trig_and_i  (trig_and_i),
        .hit_c       (trig_hit_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        post_cnt_d  = post_cnt_q;
        post_left_d = post_left_q;
        n_samples_d = n_samples_o;
        trig_addr_d = trig_addr_o;
        buf_addr_d  = buf_addr_o;
        buf_wdata_d = buf_wdata_o;
        buf_we_d    = 1'b0;

        if (clear_i) begin
            state_d = ILA_IDLE;
        end else begin
            case (state_q)
                ILA_IDLE, ILA_DONE: begin
                    if (arm_i) begin
                        state_d     = ILA_PRE;
                        wr_ptr_d    = '0;
                        n_samples_d = '0;
                        post_cnt_d  = post_cnt_i;
                    end
                end
                ILA_PRE, ILA_POST: begin
                    buf_we_d    = 1'b1;
                    buf_addr_d  = wr_ptr_q;
                    buf_wdata_d = data_i;
                    wr_ptr_d    = wr_ptr_q + BUF_AW'(1);
                    if (n_samples_o != DEPTH) begin
                        n_samples_d = n_samples_o + CNT_W'(1);
                    end
                    if (state_q == ILA_PRE) begin
                        if (trig_hit_c) begin
                            trig_addr_d = wr_ptr_q;
                            if (post_cnt_q == '0) begin
                                state_d = ILA_DONE;
                            end else begin
                                state_d     = ILA_POST;
                                post_left_d = post_cnt_q;
                            end
                        end
                    end else begin
                        post_left_d = post_left_q - BUF_AW'(1);
                        if (post_left_q == BUF_AW'(1)) begin
                            state_d = ILA_DONE;
                        end
                    end
                end
                default: state_d = ILA_IDLE;
            endcase
        end

        done_d = (state_d == ILA_DONE);
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q     <= ILA_IDLE;
            wr_ptr_q    <= '0;
            post_cnt_q  <= '0;
            post_left_q <= '0;
            n_samples_o <= '0;
            trig_addr_o <= '0;
            buf_we_o    <= 1'b0;
            buf_addr_o  <= '0;
            buf_wdata_o <= '0;
            done_o      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            post_cnt_q  <= post_cnt_d;
            post_left_q <= post_left_d;
            n_samples_o <= n_samples_d;
            trig_addr_o <= trig_addr_d;
            buf_we_o    <= buf_we_d;
            buf_addr_o  <= buf_addr_d;
            buf_wdata_o <= buf_wdata_d;
            done_o      <= done_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_ila_trigger_capture.sv
// Self-checking bench for ila_trigger_capture: directed scenarios plus randomized traffic vs a behavioural model.
module tb_ila_trigger_capture;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned TRIG_W = 4;
    localparam int unsigned BUF_AW = 4;
    localparam int DEPTH = 16;

    localparam int S_IDLE = 0;
    localparam int S_PRE  = 1;
    localparam int S_POST = 2;
    localparam int S_DONE = 3;

    logic              clk;
    logic              arst_n;
    logic [DATA_W-1:0] data;
    logic [TRIG_W-1:0] trig, ttype, tneg, tmask;
    logic              tand;
    logic [BUF_AW-1:0] post_cnt;
    logic              arm, clr;

    logic              buf_we_o;
    logic [BUF_AW-1:0] buf_addr_o;
    logic [DATA_W-1:0] buf_wdata_o;
    logic [BUF_AW-1:0] trig_addr_o;
    logic [BUF_AW:0]   n_samples_o;
    logic [1:0]        state_o;
    logic              done_o;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    int          m_state, m_ptr, m_n, m_post, m_left, m_taddr, m_addr;
    bit          m_we;
    logic [31:0] m_wdata;
    logic [3:0]  m_xq;

    ila_trigger_capture #(
        .DATA_W (DATA_W),
        .TRIG_W (TRIG_W),
        .BUF_AW (BUF_AW)
    ) dut (
        .clk_i       (clk),
        .arst_n_i    (arst_n),
        .data_i      (data),
        .trig_i      (trig),
        .trig_type_i (ttype),
        .trig_neg_i  (tneg),
        .trig_mask_i (tmask),
        .trig_and_i  (tand),
        .post_cnt_i  (post_cnt),
        .arm_i       (arm),
        .clear_i     (clr),
        .buf_we_o    (buf_we_o),
        .buf_addr_o  (buf_addr_o),
        .buf_wdata_o (buf_wdata_o),
        .trig_addr_o (trig_addr_o),
        .n_samples_o (n_samples_o),
        .state_o     (state_o),
        .done_o      (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_ptr = 0; m_n = 0; m_post = 0; m_left = 0;
        m_taddr = 0; m_addr = 0; m_we = 0; m_wdata = '0; m_xq = '0;
    endtask

    // One clock of the reference behaviour, using the inputs present at the edge.
    task automatic model_step();
        logic [3:0] x, hb;
        bit fire;
        if (!arst_n) begin
            model_reset();
            return;
        end
        x = trig ^ tneg;
        for (int i = 0; i < 4; i++) hb[i] = ttype[i] ? (x[i] & ~m_xq[i]) : x[i];
        if (tmask == 4'd0)  fire = 0;
        else if (tand)      fire = ((hb & tmask) == tmask);
        else                fire = ((hb & tmask) != 4'd0);
        m_xq = x;
        m_we = 0;
        if (clr) begin
            m_state = S_IDLE;
        end else if (m_state == S_IDLE || m_state == S_DONE) begin
            if (arm) begin
                m_state = S_PRE; m_ptr = 0; m_n = 0; m_post = int'(post_cnt);
            end
        end else begin
            m_we = 1; m_addr = m_ptr; m_wdata = data;
            if (m_state == S_PRE) begin
                if (fire) begin
                    m_taddr = m_ptr;
                    if (m_post == 0) m_state = S_DONE;
                    else begin m_state = S_POST; m_left = m_post; end
                end
            end else begin
                if (m_left == 1) m_state = S_DONE;
                m_left--;
            end
            m_ptr = (m_ptr + 1) % DEPTH;
            m_n   = (m_n + 1 > DEPTH) ? DEPTH : m_n + 1;
        end
    endtask

    task automatic compare_all();
        check("state", 64'(state_o), 64'(m_state));
        check("done", 64'(done_o), 64'(m_state == S_DONE));
        check("we", 64'(buf_we_o), 64'(m_we));
        if (m_we) begin
            check("addr", 64'(buf_addr_o), 64'(m_addr));
            check("wdata", 64'(buf_wdata_o), 64'(m_wdata));
        end
        check("trig_addr", 64'(trig_addr_o), 64'(m_taddr));
        check("n_samples", 64'(n_samples_o), 64'(m_n));
    endtask

    // Edge with current inputs, then compare at the following falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        data = $urandom;
        compare_all();
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("rst_addr", 64'(buf_addr_o), 64'd0);
        check("rst_wdata", 64'(buf_wdata_o), 64'd0);
        tick();
        tick();
        arst_n = 1'b1;
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic clear_pulse();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        arst_n = 1'b1; data = '0; trig = '0; ttype = '0; tneg = '0; tmask = '0;
        tand = 1'b0; post_cnt = '0; arm = 1'b0; clr = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Level trigger on bit 0, five cycles after arming, three post samples.
        tmask = 4'b0001; ttype = 4'b0000; post_cnt = 4'd3;
        arm_pulse();
        repeat (5) tick();
        trig = 4'b0001;
        tick();
        repeat (3) tick();
        check("lvl_trig_addr", 64'(trig_addr_o), 64'd5);
        check("lvl_n_samples", 64'(n_samples_o), 64'd9);
        check("lvl_state", 64'(state_o), 64'd3);
        tick();
        check("lvl_hold_we", 64'(buf_we_o), 64'd0);

        // Edge + negate on bit 1: fires once on the 1->0 fall; a held 0 never re-fires.
        trig = 4'b0010; tmask = 4'b0010; ttype = 4'b0010; tneg = 4'b0010; post_cnt = 4'd2;
        tick();
        arm_pulse();
        repeat (3) tick();
        trig = 4'b0000;
        tick();
        repeat (2) tick();
        check("edge_done", 64'(state_o), 64'd3);
        arm_pulse();
        repeat (10) tick();
        check("edge_no_refire", 64'(state_o), 64'd1);
        clear_pulse();

        // AND vs OR with mask 0011.
        ttype = '0; tneg = '0; tmask = 4'b0011; tand = 1'b1; post_cnt = 4'd1; trig = 4'b0001;
        arm_pulse();
        repeat (4) tick();
        check("and_no_fire", 64'(state_o), 64'd1);
        trig = 4'b0011;
        tick();
        check("and_fire", 64'(state_o), 64'd2);
        tick();
        tand = 1'b0; trig = 4'b0001;
        arm_pulse();
        tick();
        check("or_fire", 64'(state_o), 64'd2);
        tick();

        // Wrap: 40 pre-trigger samples, then trigger, five post.
        tmask = 4'b0001; post_cnt = 4'd5; trig = 4'b0000;
        arm_pulse();
        repeat (40) tick();
        trig = 4'b0001;
        tick();
        trig = 4'b0000;
        repeat (5) tick();
        check("wrap_trig_addr", 64'(trig_addr_o), 64'd8);
        check("wrap_n_samples", 64'(n_samples_o), 64'd16);
        check("wrap_done", 64'(done_o), 64'd1);

        // post=0, arm+clear together, clear in POST.
        post_cnt = 4'd0;
        arm_pulse();
        tick();
        trig = 4'b0001;
        tick();
        check("post0_done", 64'(state_o), 64'd3);
        arm = 1'b1; clr = 1'b1;
        tick();
        arm = 1'b0; clr = 1'b0;
        check("armclr_idle", 64'(state_o), 64'd0);
        post_cnt = 4'd9;
        arm_pulse();
        tick();
        tick();
        clear_pulse();
        check("clr_we", 64'(buf_we_o), 64'd0);

        // Reset in the middle of POST.
        trig = 4'b0000;
        arm_pulse();
        trig = 4'b0001;
        repeat (4) tick();
        do_reset();
        check("rst_state", 64'(state_o), 64'd0);
        repeat (3) tick();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                tmask = 4'($urandom); ttype = 4'($urandom); tneg = 4'($urandom);
                tand = 1'($urandom); post_cnt = 4'($urandom);
            end
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) trig[b] = ~trig[b];
            arm = ($urandom_range(0, 24) == 0);
            clr = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 599) == 0) begin
                arm = 1'b0; clr = 1'b0;
                do_reset();
            end else begin
                tick();
            end
        end
        arm = 1'b0; clr = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
